// File: rtl/mips_multicycle.sv
// Shared-memory multi-cycle MIPS subset core, one instruction in flight.
// Define MIPS_MC_JUMP_EN to add the j instruction (opcode 0x02).
`timescale 1ns/1ps
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [31:0]       ula_result,
    output logic [2:0]        state,
    output logic              trap
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

`ifdef MIPS_MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] simm, addr_calc, exec_res, addr_full;
    logic        r_ok, op_ok, is_mem, is_br;

    assign op   = ir_q[31:26];
    assign rs   = ir_q[25:21];
    assign rt   = ir_q[20:16];
    assign rd   = ir_q[15:11];
    assign sh   = ir_q[10:6];
    assign fn   = ir_q[5:0];
    assign simm = {{16{ir_q[15]}}, ir_q[15:0]};

    assign addr_calc = a_q + simm;
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
    assign is_br     = (op == OP_BEQ) || (op == OP_BNE);

    always_comb begin
        r_ok  = (op == OP_R) &&
                (fn inside {F_SLL, F_ADD, F_SUB, F_AND, F_OR, F_SLT});
        op_ok = r_ok || is_mem || is_br || (op == OP_ADDI) ||
                (JUMP_EN && (op == OP_J));
    end

    // Non-R opcodes reaching EXEC all want A + sign_ext(imm).
    always_comb begin
        exec_res = addr_calc;
        if (op == OP_R) begin
            case (fn)
                F_SUB:   exec_res = a_q - b_q;
                F_AND:   exec_res = a_q & b_q;
                F_OR:    exec_res = a_q | b_q;
                F_SLT:   exec_res = {31'b0, $signed(a_q) < $signed(b_q)};
                F_SLL:   exec_res = b_q << sh;
                default: exec_res = a_q + b_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_full = pc_q;
        unique case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = op_ok ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_mem)
                    state_d = (addr_calc[1:0] != 2'b00) ? S_TRAP : S_MEM;
                else if (is_br || op == OP_J)
                    state_d = S_FETCH;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_SW);
                addr_full = alu_q;
                if (mem_ready) state_d = (op == OP_SW) ? S_FETCH : S_WB;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
    end

    logic [4:0]  wb_dst;
    logic [31:0] wb_val;
    assign wb_dst = (op == OP_R) ? rd : rt;
    assign wb_val = (op == OP_LW) ? mdr_q : alu_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ready) begin
                    ir_q <= mem_rdata;
                    pc_q <= pc_q + 32'd4;
                end
                S_DECODE: begin
                    a_q   <= (rs == 5'd0) ? 32'd0 : rf_q[rs];
                    b_q   <= (rt == 5'd0) ? 32'd0 : rf_q[rt];
                    alu_q <= pc_q + {simm[29:0], 2'b00};
                end
                S_EXEC: begin
                    if (is_br) begin
                        if ((a_q == b_q) == (op == OP_BEQ)) pc_q <= alu_q;
                    end else if (op == OP_J) begin
                        pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                    end else begin
                        alu_q <= exec_res;
                    end
                end
                S_MEM: if (mem_ready && op == OP_LW) mdr_q <= mem_rdata;
                S_WB:  if (wb_dst != 5'd0) rf_q[wb_dst] <= wb_val;
                default: ;
            endcase
        end
    end

    assign mem_addr   = addr_full[ADDR_W-1:0];
    assign mem_wdata  = b_q;
    assign pc         = pc_q;
    assign ula_result = alu_q;
    assign state      = state_q;
    assign trap       = (state_q == S_TRAP);
endmodule

// File: tb/tb_mips_multicycle.sv
// Scoreboard bench for mips_multicycle: fetch trace and store queues.
// Data accesses get a programmable number of wait cycles; fetches do not.
`timescale 1ns/1ps
module tb_mips_multicycle;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, ula_result;
    logic [2:0]  state;

    mips_multicycle #(.RESET_PC(32'h100)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .ula_result(ula_result),
        .state(state), .trap(trap)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
        bit          chk_ula;
        logic [31:0] ula;
    } fexp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    fexp_t fq[$];
    wexp_t wq[$];
    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] mem [256];
    logic [31:0] img [256];
    int unsigned wcnt = 0;
    int unsigned dwait = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // memory model
    always_comb begin
        mem_rdata = mem[mem_addr[9:2]];
        mem_ready = mem_req && (wcnt >= ((state == 3'd3) ? dwait : 0));
    end

    always @(posedge clock) begin
        if (reset) begin
            wcnt <= 0;
            cyc  <= 0;
            mem  <= img;
        end else begin
            cyc <= cyc + 1;
            if (mem_req) begin
                if (mem_ready) begin
                    wcnt <= 0;
                    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // monitor
    logic        st_prev = 1'b0;
    logic [2:0]  p_state;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;

    always @(negedge clock) begin
        fexp_t f;
        wexp_t w;
        if (!reset && mem_req && mem_ready && state == 3'd0 && fq.size() > 0) begin
            f = fq.pop_front();
            chk("fetch_addr", mem_addr, f.addr);
            chk("fetch_pc", pc, f.addr);
            chk("fetch_cyc", 32'(cyc), 32'(f.cyc));
            if (f.chk_ula) chk("ula_result", ula_result, f.ula);
        end
        if (!reset && mem_req && mem_ready && mem_we) begin
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", mem_addr, w.addr);
                chk("wr_data", mem_wdata, w.data);
            end else begin
                chk("unexpected_wr", mem_addr, 32'hFFFF_FFFF);
            end
        end
        if (!reset && st_prev && mem_req && state == p_state) begin
            chk("stall_addr", mem_addr, p_addr);
            chk("stall_wdata", mem_wdata, p_wdata);
            chk("stall_we", 32'(mem_we), 32'(p_we));
        end
        st_prev <= !reset && mem_req && !mem_ready;
        p_state <= state;
        p_addr  <= mem_addr;
        p_wdata <= mem_wdata;
        p_we    <= mem_we;
    end

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op,
                                          input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic void push_f(input logic [31:0] a, input int c);
        fq.push_back('{a, c, 1'b0, 32'h0});
    endfunction
    function automatic void push_fu(input logic [31:0] a, input int c,
                                    input logic [31:0] u);
        fq.push_back('{a, c, 1'b1, u});
    endfunction
    function automatic void push_w(input logic [31:0] a, input logic [31:0] d);
        wq.push_back('{a, d});
    endfunction

    function automatic void clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endfunction
    function automatic void put(input int a, input logic [31:0] w);
        img[a >> 2] = w;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string nm);
        @(negedge clock);
        chk({nm, "_req"}, 32'(mem_req), 32'd1);
        chk({nm, "_addr"}, mem_addr, 32'h100);
        chk({nm, "_pc"}, pc, 32'h100);
        chk({nm, "_state"}, 32'(state), 32'd0);
        chk({nm, "_trap"}, 32'(trap), 32'd0);
        chk({nm, "_ula"}, ula_result, 32'd0);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while ((fq.size() > 0 || wq.size() > 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (fq.size() > 0 || wq.size() > 0) begin
            n_run++;
            n_fail++;
            $display("FAIL %s: timeout, %0d fetch and %0d write left, need 0",
                     nm, fq.size(), wq.size());
            fq.delete();
            wq.delete();
        end
    endtask

    task automatic trap_hold(input string nm, input logic [31:0] exp_pc);
        int n = 0;
        while (!trap && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_enter"}, 32'(trap), 32'd1);
        repeat (20) begin
            @(negedge clock);
            chk({nm, "_hold"}, {27'b0, state, trap, mem_req}, {27'b0, 3'd7, 2'b10});
            chk({nm, "_pc"}, pc, exp_pc);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] loop_i;
        int n;
        loop_i = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);

        // reset state + addi/addi/add
        clear_img();
        put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h104, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        put(32'h108, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        put(32'h10C, enc_i(6'h2B, 5'd0, 5'd3, 16'h20));
        put(32'h110, loop_i);
        dwait = 0;
        do_reset();
        push_f(32'h100, 0);
        push_f(32'h104, 4);
        push_f(32'h108, 8);
        push_fu(32'h10C, 12, 32'd2);
        push_f(32'h110, 16);
        push_f(32'h110, 19);
        push_w(32'h20, 32'd2);
        check_reset_state("rst");
        wait_drain("add", 100);

        // ALU ops, slt signedness, sll, write to $0
        clear_img();
        put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h104, enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        put(32'h108, enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h22));
        put(32'h10C, enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h24));
        put(32'h110, enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h25));
        put(32'h114, enc_r(5'd2, 5'd1, 5'd6, 5'd0, 6'h2A));
        put(32'h118, enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h2A));
        put(32'h11C, enc_r(5'd0, 5'd1, 5'd8, 5'd4, 6'h00));
        put(32'h120, enc_i(6'h08, 5'd1, 5'd0, 16'd7));
        put(32'h124, enc_i(6'h2B, 5'd0, 5'd3, 16'h20));
        put(32'h128, enc_i(6'h2B, 5'd0, 5'd4, 16'h24));
        put(32'h12C, enc_i(6'h2B, 5'd0, 5'd5, 16'h28));
        put(32'h130, enc_i(6'h2B, 5'd0, 5'd6, 16'h2C));
        put(32'h134, enc_i(6'h2B, 5'd0, 5'd7, 16'h30));
        put(32'h138, enc_i(6'h2B, 5'd0, 5'd8, 16'h34));
        put(32'h13C, enc_i(6'h2B, 5'd0, 5'd0, 16'h38));
        put(32'h140, loop_i);
        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i == 9) push_fu(32'h100 + 32'(4 * i), 4 * i, 32'd12);
            else        push_f(32'h100 + 32'(4 * i), 4 * i);
        end
        push_f(32'h140, 67);
        push_f(32'h140, 70);
        push_w(32'h20, 32'd8);
        push_w(32'h24, 32'd5);
        push_w(32'h28, 32'hFFFF_FFFD);
        push_w(32'h2C, 32'd1);
        push_w(32'h30, 32'd0);
        push_w(32'h34, 32'h50);
        push_w(32'h38, 32'd0);
        wait_drain("alu", 200);

        // sw/lw with 2 data wait cycles
        clear_img();
        put(32'h100, enc_i(6'h08, 5'd0, 5'd1, 16'hDEAE));
        put(32'h104, enc_r(5'd0, 5'd1, 5'd1, 5'd16, 6'h00));
        put(32'h108, enc_i(6'h08, 5'd1, 5'd1, 16'hBEEF));
        put(32'h10C, enc_i(6'h2B, 5'd0, 5'd1, 16'h8));
        put(32'h110, enc_i(6'h23, 5'd0, 5'd4, 16'h8));
        put(32'h114, enc_i(6'h2B, 5'd0, 5'd4, 16'hC));
        put(32'h118, loop_i);
        dwait = 2;
        do_reset();
        push_f(32'h100, 0);
        push_f(32'h104, 4);
        push_f(32'h108, 8);
        push_f(32'h10C, 12);
        push_f(32'h110, 18);
        push_f(32'h114, 25);
        push_f(32'h118, 31);
        push_f(32'h118, 34);
        push_w(32'h8, 32'hDEAD_BEEF);
        push_w(32'hC, 32'hDEAD_BEEF);
        wait_drain("lwsw", 100);

        // bne not taken, beq to 0x40, beq self-loop
        clear_img();
        put(32'h100, enc_i(6'h05, 5'd0, 5'd0, 16'hFFFF));
        put(32'h104, enc_i(6'h04, 5'd0, 5'd0, 16'hFFCE));
        put(32'h40, loop_i);
        dwait = 0;
        do_reset();
        push_f(32'h100, 0);
        push_f(32'h104, 3);
        push_f(32'h40, 6);
        push_f(32'h40, 9);
        push_f(32'h40, 12);
        wait_drain("branch", 100);

        // misaligned lw traps, then reset recovers
        clear_img();
        put(32'h100, enc_i(6'h23, 5'd0, 5'd1, 16'd2));
        do_reset();
        push_f(32'h100, 0);
        wait_drain("mis_fetch", 20);
        trap_hold("mis", 32'h104);
        clear_img();
        put(32'h100, {6'h3F, 26'h0});
        do_reset();
        push_f(32'h100, 0);
        check_reset_state("rst2");
        wait_drain("bad_fetch", 20);
        trap_hold("badop", 32'h104);

        // j 0x40 at 0x10
        clear_img();
        put(32'h100, enc_i(6'h04, 5'd0, 5'd0, 16'hFFC3));
        put(32'h10, {6'h02, 26'h40});
        do_reset();
        push_f(32'h100, 0);
        push_f(32'h10, 3);
`ifdef MIPS_MC_JUMP_EN
        push_f(32'h100, 6);
        push_f(32'h10, 9);
        wait_drain("jump", 50);
`else
        wait_drain("jump", 50);
        trap_hold("j", 32'h14);
`endif

        // reset during a stalled store abandons it
        clear_img();
        put(32'h100, enc_i(6'h2B, 5'd0, 5'd1, 16'h40));
        put(32'h104, enc_i(6'h08, 5'd0, 5'd1, 16'd9));
        put(32'h108, enc_i(6'h2B, 5'd0, 5'd1, 16'h44));
        put(32'h10C, loop_i);
        dwait = 5;
        do_reset();
        push_w(32'h40, 32'd0);
        n = 0;
        while (!(state == 3'd3 && mem_addr == 32'h44) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("mid_reach", 32'(state), 32'd3);
        do_reset();
        push_w(32'h40, 32'd0);
        push_w(32'h44, 32'd9);
        check_reset_state("rst3");
        wait_drain("mid", 100);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter ADDR_W, default 32, width of mem_addr (low ADDR_W bits of 32-bit byte address).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port mem_req  output  1  memory access request.
REQ-006 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 SHALL have port mem_addr  output  ADDR_W  byte address.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  read data; valid in the cycle mem_ready=1.
REQ-010 SHALL have port mem_ready  input  1  access completes on an edge where mem_req=1 and mem_ready=1.
REQ-011 SHALL have port pc  output  32  current PC register.
REQ-012 SHALL have port ula_result  output  32  ALU output register.
REQ-013 SHALL have port state  output  3  FSM state encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-014 SHALL have port trap  output  1  high while in TRAP.

Function
REQ-015 SHALL be a shared-memory multi-cycle core; one instruction in flight; internal 32x32 register file, IR, A, B, ALUOut, MDR registers.
REQ-016 SHALL support: R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00 (shamt = instr[10:6]); opcodes addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=pc; hold until mem_ready; on the completing edge: IR<=mem_rdata, pc<=pc+4 (mod 2^32), go to DECODE.
REQ-018 DECODE (1 cycle): A<=reg[rs], B<=reg[rt], ALUOut<=pc + (sign_ext(imm)<<2); unsupported opcode/funct -> TRAP, otherwise -> EXEC.
REQ-019 EXEC R-type/addi: ALUOut<=result, -> WB; addi uses sign-extended immediate; slt is signed.
REQ-020 EXEC lw/sw: ALUOut<=A+sign_ext(imm); address[1:0]!=0 -> TRAP, else -> MEM.
REQ-021 EXEC beq/bne: taken when (A==B) for beq, (A!=B) for bne; taken -> pc<=ALUOut; -> FETCH either way.
REQ-022 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 and mem_wdata=B for sw; hold until mem_ready; sw -> FETCH; lw: MDR<=mem_rdata, -> WB.
REQ-023 WB: write ALUOut (R-type: rd; addi: rt) or MDR (lw: rt); -> FETCH.
REQ-024 Writes to register 0 SHALL be discarded; reg[0] reads as 0.
REQ-025 mem_we, mem_addr, mem_wdata SHALL be stable while mem_req=1 and mem_ready=0; mem_req=0 in DECODE, EXEC, WB, TRAP.
REQ-026 With zero-wait memory (mem_ready tied 1), latency SHALL be: R-type/addi 4, lw 5, sw 4, beq/bne 3 cycles; each wait cycle adds 1.
REQ-027 TRAP SHALL be absorbing: no PC, register or memory updates until reset.

Reset
REQ-028 On reset edge: state=FETCH, pc=RESET_PC, all registers and IR/A/B/ALUOut/MDR=0, trap=0; mem_req SHALL be 1 in the first cycle after reset (FETCH).
REQ-029 Reset asserted mid-access SHALL abandon the access; no register write or PC update from the abandoned instruction.

Configuration
REQ-030 Macro MIPS_MC_JUMP_EN defined: opcode 0x02 (j) supported; EXEC sets pc<={pc[31:28], instr[25:0], 2'b00}, -> FETCH; latency 3 cycles.
REQ-031 Macro MIPS_MC_JUMP_EN undefined: opcode 0x02 SHALL be unsupported and enter TRAP from DECODE.

Verification
REQ-032 Reset RESET_PC=0x100, mem_ready=1 -> first cycle mem_req=1, mem_addr=0x100, state=0.
REQ-033 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2 -> reg[3]=2, ula_result=2, pc=RESET_PC+12 after 12 cycles.
REQ-034 sw $1,8($0) with reg[1]=0xDEADBEEF then lw $4,8($0), mem_ready low 2 cycles per access -> write seen at addr 8 data 0xDEADBEEF; reg[4]=0xDEADBEEF; lw takes 7 cycles.
REQ-035 beq $0,$0,-1 at 0x40 -> pc returns to 0x40 every 3 cycles; bne $0,$0,-1 -> pc=0x44.
REQ-036 lw $1,2($0) or opcode 0x3F -> state=7, trap=1, mem_req=0 held 20 cycles; reset -> FETCH at RESET_PC.
REQ-037 j 0x0000040 with MIPS_MC_JUMP_EN at pc=0x10 -> pc=0x100 after 3 cycles; without macro -> trap=1.
